// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto one fixed-latency synchronous memory.
// Define ARB_FIXED_PRIO_EN for fixed CPU priority; the default is round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              win_dma_q;
    logic              win_dma_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_gnt_q, dma_gnt_q;
    logic              cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              mem_en_q, mem_we_q;
    logic              busy_q;
`ifndef ARB_FIXED_PRIO_EN
    logic              prefer_dma_q;
`endif

    // Winner chosen from the requests sampled in IDLE.
    always_comb begin
        win_dma_d = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        win_dma_d = ~cpu_req_i;
`else
        if (cpu_req_i && dma_req_i) begin
            win_dma_d = prefer_dma_q;
        end else begin
            win_dma_d = dma_req_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Data registers are reset too: every output must read 0 after reset.
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_dma_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            prefer_dma_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking defaults make the strobes single-cycle pulses; a
            // later assignment in the case below overrides them for this edge only.
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_i || dma_req_i) begin
                        win_dma_q <= win_dma_d;
                        we_q      <= win_dma_d ? dma_we_i    : cpu_we_i;
                        addr_q    <= win_dma_d ? dma_addr_i  : cpu_addr_i;
                        wdata_q   <= win_dma_d ? dma_wdata_i : cpu_wdata_i;
                        mem_en_q  <= 1'b1;
                        mem_we_q  <= win_dma_d ? dma_we_i    : cpu_we_i;
                        cpu_gnt_q <= ~win_dma_d;
                        dma_gnt_q <= win_dma_d;
                        busy_q    <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                        prefer_dma_q <= ~win_dma_d;
`endif
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CNT_W'(MEM_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Count of zero marks the cycle mem_rdata is valid.
                    if (cnt_q == '0) begin
                        if (win_dma_q) begin
                            dma_rdata_q <= we_q ? '0 : mem_rdata_i;
                        end else begin
                            cpu_rdata_q <= we_q ? '0 : mem_rdata_i;
                        end
                        cpu_rvalid_q <= ~win_dma_q;
                        dma_rvalid_q <= win_dma_q;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign dma_gnt_o    = dma_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dma_rvalid_o = dma_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dma_rdata_o  = dma_rdata_q;
    assign cpu_stall_o  = cpu_req_i & ~cpu_rvalid_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2 and MEM_LAT=1) against a
// transaction-schedule model, plus literal checks of the directed scenarios.
module tb_mem_port_arbiter;

    localparam int NDUT = 2;
    localparam int NCYC = 4000;
`ifdef ARB_FIXED_PRIO_EN
    localparam int EXP_ORDER [4] = '{0, 0, 0, 0};
`else
    localparam int EXP_ORDER [4] = '{0, 1, 0, 1};
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index [dut][requester], requester 0 = CPU, 1 = DMA.
    logic        req    [NDUT][2];
    logic        we     [NDUT][2];
    logic [31:0] addr   [NDUT][2];
    logic [31:0] wdata  [NDUT][2];
    logic        gnt    [NDUT][2];
    logic        rvalid [NDUT][2];
    logic [31:0] rdata  [NDUT][2];
    logic        stall  [NDUT][2];
    logic        mem_en [NDUT];
    logic        mem_we [NDUT];
    logic        busy   [NDUT];
    logic [31:0] mem_addr  [NDUT];
    logic [31:0] mem_wdata [NDUT];
    logic [31:0] mem_rdata [NDUT];
    logic        dma_stall_unused [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 2 : 1)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .cpu_req_i   (req[g][0]),
            .cpu_we_i    (we[g][0]),
            .cpu_addr_i  (addr[g][0]),
            .cpu_wdata_i (wdata[g][0]),
            .cpu_gnt_o   (gnt[g][0]),
            .cpu_rvalid_o(rvalid[g][0]),
            .cpu_rdata_o (rdata[g][0]),
            .cpu_stall_o (stall[g][0]),
            .dma_req_i   (req[g][1]),
            .dma_we_i    (we[g][1]),
            .dma_addr_i  (addr[g][1]),
            .dma_wdata_i (wdata[g][1]),
            .dma_gnt_o   (gnt[g][1]),
            .dma_rvalid_o(rvalid[g][1]),
            .dma_rdata_o (rdata[g][1]),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g]),
            .busy_o      (busy[g])
        );
        assign stall[g][1] = req[g][1] & ~rvalid[g][1];
        assign dma_stall_unused[g] = stall[g][1];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: a transaction sampled at cycle t0 owns cycles t0+1 .. t0+2+L.
    bit          act_m   [NDUT];
    int          t0_m    [NDUT];
    int          win_m   [NDUT];
    bit          we_m    [NDUT];
    logic [31:0] addr_m  [NDUT];
    logic [31:0] wdata_m [NDUT];
    bit          pref_dma_m [NDUT];
    logic [31:0] rdh_m   [NDUT][2];
    logic [31:0] mem     [NDUT][64];
    int          rd_cyc  [NDUT];
    logic [31:0] rd_val  [NDUT];

    int          a_gnt [NDUT], a_rv [NDUT], a_stall [NDUT];
    logic [31:0] a_maddr [NDUT], a_rd [NDUT];
    int          b_we [NDUT], b_rv [NDUT];
    logic [31:0] b_wd [NDUT], b_rd [NDUT];
    logic        c_busy [NDUT], c_men [NDUT];
    int          c_rv [NDUT];
    int          d_cnt [NDUT];
    int          d_who [NDUT][4];
    int          d_cyc [NDUT][4];

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic checkw(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic checkb(input string name, input int d, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %b expected %b", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        act_m[d]      = 1'b0;
        t0_m[d]       = -100;
        pref_dma_m[d] = 1'b0;
        addr_m[d]     = '0;
        wdata_m[d]    = '0;
        we_m[d]       = 1'b0;
        rdh_m[d][0]   = '0;
        rdh_m[d][1]   = '0;
    endtask

    task automatic drive(input int k);
        rst = (k < 3) || (k == 25) || (k == 30) ||
              (k >= 56 && k < NCYC && $urandom_range(0, 399) == 0);
        for (int d = 0; d < NDUT; d++) begin
            mem_rdata[d] = (rd_cyc[d] == k) ? rd_val[d] : $urandom();
            for (int r = 0; r < 2; r++) begin
                if (rst) begin
                    req[d][r] = 1'b0;
                end else if (k == 3 && r == 0) begin
                    req[d][r] = 1'b1; we[d][r] = 1'b0; addr[d][r] = 32'h10; wdata[d][r] = 32'h0;
                end else if (k == 13 && r == 1) begin
                    req[d][r] = 1'b1; we[d][r] = 1'b1; addr[d][r] = 32'h20; wdata[d][r] = 32'h12345678;
                end else if (k == 23 && r == 0) begin
                    req[d][r] = 1'b1; we[d][r] = 1'b0; addr[d][r] = 32'h11; wdata[d][r] = 32'h0;
                end else if (k >= 31 && k <= 55) begin
                    req[d][r] = 1'b1; we[d][r] = 1'b0; addr[d][r] = 32'h30 + r; wdata[d][r] = 32'h0;
                end else if (k >= 56 && k < NCYC) begin
                    if (rvalid[d][r] === 1'b1) req[d][r] = ($urandom_range(0, 1) == 1);
                    else if (!req[d][r])       req[d][r] = ($urandom_range(0, 2) == 0);
                    // Fields wander every cycle; only the value at the IDLE sample matters.
                    we[d][r]    = ($urandom_range(0, 1) == 1);
                    addr[d][r]  = $urandom_range(0, 63);
                    wdata[d][r] = $urandom();
                end else begin
                    req[d][r] = req[d][r] & ~(rvalid[d][r] === 1'b1);
                end
            end
        end
    endtask

    task automatic compare(input int d, input int k);
        int   L;
        int   rel;
        logic e_issue, e_done;
        L       = lat(d);
        rel     = k - t0_m[d];
        e_issue = act_m[d] && rel == 1;
        e_done  = act_m[d] && rel == L + 2;
        checkb("busy", d, busy[d], act_m[d] && rel >= 1 && rel <= L + 2);
        checkb("mem_en", d, mem_en[d], e_issue);
        checkb("mem_we", d, mem_we[d], e_issue && we_m[d]);
        checkw("mem_addr", d, mem_addr[d], addr_m[d]);
        checkw("mem_wdata", d, mem_wdata[d], wdata_m[d]);
        for (int r = 0; r < 2; r++) begin
            checkb(r == 0 ? "cpu_gnt" : "dma_gnt", d, gnt[d][r], e_issue && win_m[d] == r);
            checkb(r == 0 ? "cpu_rvalid" : "dma_rvalid", d, rvalid[d][r], e_done && win_m[d] == r);
            checkw(r == 0 ? "cpu_rdata" : "dma_rdata", d, rdata[d][r], rdh_m[d][r]);
        end
        checkb("cpu_stall", d, stall[d][0], req[d][0] && !(e_done && win_m[d] == 0));
    endtask

    task automatic observe(input int d, input int k);
        if (k >= 3 && k <= 12) begin
            if (gnt[d][0] === 1'b1 && a_gnt[d] < 0) begin a_gnt[d] = k; a_maddr[d] = mem_addr[d]; end
            if (rvalid[d][0] === 1'b1 && a_rv[d] < 0) begin a_rv[d] = k; a_rd[d] = rdata[d][0]; end
            if (stall[d][0] === 1'b1) a_stall[d]++;
        end
        if (k >= 13 && k <= 22) begin
            if (mem_we[d] === 1'b1) begin b_we[d]++; b_wd[d] = mem_wdata[d]; end
            if (rvalid[d][1] === 1'b1) begin b_rv[d]++; b_rd[d] = rdata[d][1]; end
        end
        if (k == 26) begin c_busy[d] = busy[d]; c_men[d] = mem_en[d]; end
        if (k >= 26 && k <= 29 && (rvalid[d][0] !== 1'b0 || rvalid[d][1] !== 1'b0)) c_rv[d]++;
        if (k >= 31 && k <= 55 && d_cnt[d] < 4 && (gnt[d][0] === 1'b1 || gnt[d][1] === 1'b1)) begin
            d_who[d][d_cnt[d]] = (gnt[d][1] === 1'b1) ? 1 : 0;
            d_cyc[d][d_cnt[d]] = k;
            d_cnt[d]++;
        end
    endtask

    task automatic step(input int d, input int k);
        int L;
        int rel;
        int w;
        L   = lat(d);
        rel = k - t0_m[d];
        // Environment memory answers exactly L cycles after the strobe; junk otherwise.
        if (mem_en[d] === 1'b1) begin
            if (mem_we[d] === 1'b1) begin
                mem[d][mem_addr[d][5:0]] = mem_wdata[d];
            end else begin
                rd_cyc[d] = k + L;
                rd_val[d] = mem[d][mem_addr[d][5:0]];
            end
        end
        if (rst) begin
            model_reset(d);
        end else begin
            if (act_m[d] && rel == L + 1)
                rdh_m[d][win_m[d]] = we_m[d] ? 32'h0 : mem[d][addr_m[d][5:0]];
            if ((!act_m[d] || rel >= L + 3) && (req[d][0] || req[d][1])) begin
`ifdef ARB_FIXED_PRIO_EN
                w = req[d][0] ? 0 : 1;
`else
                if (req[d][0] && req[d][1]) w = pref_dma_m[d] ? 1 : 0;
                else                        w = req[d][0] ? 0 : 1;
                pref_dma_m[d] = (w == 0);
`endif
                act_m[d]   = 1'b1;
                t0_m[d]    = k;
                win_m[d]   = w;
                we_m[d]    = we[d][w];
                addr_m[d]  = addr[d][w];
                wdata_m[d] = wdata[d][w];
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            for (int r = 0; r < 2; r++) begin
                req[d][r] = 1'b0; we[d][r] = 1'b0; addr[d][r] = '0; wdata[d][r] = '0;
            end
            mem_rdata[d] = '0;
            for (int i = 0; i < 64; i++) mem[d][i] = $urandom();
            mem[d][16] = 32'hDEADBEEF;
            rd_cyc[d]  = -1;
            rd_val[d]  = '0;
            model_reset(d);
            a_gnt[d] = -1; a_rv[d] = -1; a_stall[d] = 0; a_maddr[d] = '0; a_rd[d] = '0;
            b_we[d] = 0; b_rv[d] = 0; b_wd[d] = '0; b_rd[d] = 32'hFFFFFFFF;
            c_busy[d] = 1'b1; c_men[d] = 1'b1; c_rv[d] = 0; d_cnt[d] = 0;
            for (int i = 0; i < 4; i++) begin d_who[d][i] = -1; d_cyc[d][i] = -100; end
        end

        for (int k = 0; k < NCYC + 30; k++) begin
            @(negedge clk);
            cyc = k;
            drive(k);
            #1;
            for (int d = 0; d < NDUT; d++) begin
                compare(d, k);
                observe(d, k);
                step(d, k);
            end
        end

        for (int d = 0; d < NDUT; d++) begin
            checkw("A_gnt_latency", d, a_gnt[d] - 3, 1);
            checkw("A_mem_addr", d, a_maddr[d], 32'h10);
            checkw("A_rvalid_latency", d, a_rv[d] - 3, (d == 0) ? 4 : 3);
            checkw("A_rdata", d, a_rd[d], 32'hDEADBEEF);
            checkw("A_stall_cycles", d, a_stall[d], (d == 0) ? 4 : 3);
            checkw("B_mem_we_cycles", d, b_we[d], 1);
            checkw("B_mem_wdata", d, b_wd[d], 32'h12345678);
            checkw("B_rvalid_count", d, b_rv[d], 1);
            checkw("B_rdata", d, b_rd[d], 32'h0);
            checkb("C_busy_after_rst", d, c_busy[d], 1'b0);
            checkb("C_mem_en_after_rst", d, c_men[d], 1'b0);
            checkw("C_rvalid_after_rst", d, c_rv[d], 0);
            checkw("D_grant_count", d, d_cnt[d], 4);
            for (int i = 0; i < 4; i++) checkw("D_order", d, d_who[d][i], EXP_ORDER[i]);
            checkw("D_first_gnt", d, d_cyc[d][0] - 31, 1);
            checkw("D_spacing", d, d_cyc[d][1] - d_cyc[d][0], (d == 0) ? 5 : 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
